// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM states and opcode-to-phase decode for spi_flash_ctrl.
// POLL exists only when SPI_FLASH_WIP_POLL_EN is defined.
package spi_flash_pkg;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_FREAD = 8'h0B;
   localparam logic [7:0] OP_PP    = 8'h02;
   localparam logic [7:0] OP_RDSR  = 8'h05;
   localparam logic [7:0] OP_RDID  = 8'h9F;
   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_RSTEN = 8'h66;
   localparam logic [7:0] OP_RST   = 8'h99;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, DATA,
`ifdef SPI_FLASH_WIP_POLL_EN
      POLL,
`endif
      GAP
   } state_t;

   typedef struct packed {
      logic has_addr;
      logic has_dummy;
      logic rd;
      logic wr;
   } phase_t;

   function automatic phase_t decode(input logic [7:0] op);
      phase_t p;
      p.has_addr  = op inside {OP_READ, OP_FREAD, OP_PP};
      p.has_dummy = op == OP_FREAD;
      p.rd        = op inside {OP_READ, OP_FREAD, OP_RDSR, OP_RDID};
      p.wr        = op == OP_PP;
      return p;
   endfunction
endpackage

// File: rtl/spi_flash_shifter.sv
// spi_flash_shifter: mode-3 MCLK divider plus 8-bit shift in/out; stalls MCLK high until a byte is loaded.
module spi_flash_shifter #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ld_valid,
   input  logic [7:0] ld_byte,
   input  logic [3:0] ld_bits,
   input  logic       miso,
   output logic       need,
   output logic       byte_end,
   output logic       mclk,
   output logic       mosi,
   output logic [7:0] rx
);
   localparam logic [15:0] DIV_TOP = 16'(CLK_DIV - 1);
   logic [15:0] cnt;
   logic [3:0] bits;
   logic [7:0] tx, sh;
   logic tick;
   assign tick = en && cnt == DIV_TOP;
   assign need = tick && mclk && bits == 4'd0;
   assign byte_end = tick && !mclk && bits == 4'd1;
   assign rx = {sh[6:0], miso};
   // A pending falling edge with no bits left waits here, holding cnt at DIV_TOP
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         bits <= '0;
         mclk <= 1'b1;
         mosi <= 1'b0;
         tx <= '0;
         sh <= '0;
      end else if (!en) begin
         cnt <= '0;
         bits <= '0;
         mclk <= 1'b1;
      end else if (!tick) begin
         cnt <= cnt + 16'd1;
      end else if (mclk) begin
         if (bits != 4'd0 || ld_valid) begin
            cnt <= '0;
            mclk <= 1'b0;
            mosi <= bits != 4'd0 ? tx[7] : ld_byte[7];
            tx <= bits != 4'd0 ? {tx[6:0], 1'b0} : {ld_byte[6:0], 1'b0};
            if (bits == 4'd0) bits <= ld_bits;
         end
      end else begin
         cnt <= '0;
         mclk <= 1'b1;
         sh <= rx;
         bits <= bits - 4'd1;
      end
endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: SPI NOR flash command sequencer (mode 3).
// Define SPI_FLASH_WIP_POLL_EN to poll status after page program until WIP clears.
module spi_flash_ctrl import spi_flash_pkg::*; #(
   parameter int CLK_DIV      = 2,
   parameter int ADDR_BYTES   = 3,
   parameter int DUMMY_CYCLES = 8,
   parameter int LEN_W        = 9
) (
   input  logic                    interfaceClk,
   input  logic                    reset,
   input  logic                    cmdValid,
   output logic                    cmdReady,
   input  logic [7:0]              fCommand,
   input  logic [8*ADDR_BYTES-1:0] fAddress,
   input  logic [LEN_W-1:0]        fLength,
   input  logic [7:0]              fData_WR,
   input  logic                    WrDataValid,
   output logic                    WrDataReady,
   output logic [7:0]              fData_RD,
   output logic                    RdDataValid,
   output logic                    busy,
   output logic                    done,
   input  logic                    MISO,
   output logic                    MOSI,
   output logic                    MCLK,
   output logic                    CS_n
);
   localparam logic [15:0] DIV_TOP = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_END = 16'(CLK_DIV + 3);
   state_t state, nxt, after_dummy, after_addr;
   phase_t info;
   logic [7:0] op, ld_byte, rx;
   logic [8*ADDR_BYTES-1:0] addr_sh;
   logic [LEN_W-1:0] len;
   logic [2:0] acnt;
   logic [15:0] dcnt, gcnt;
   logic [3:0] ld_bits;
   logic en, ld_valid, need, byte_end, load, gap_end, poll_go;

   spi_flash_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk(interfaceClk), .rst(reset), .en(en), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_bits(ld_bits), .miso(MISO), .need(need), .byte_end(byte_end), .mclk(MCLK),
      .mosi(MOSI), .rx(rx)
   );

   assign load = need && ld_valid;
   assign gap_end = state == GAP && gcnt == GAP_END;

`ifdef SPI_FLASH_WIP_POLL_EN
   logic polled, poll_rd;
   assign poll_go = info.wr && !polled;
`else
   assign poll_go = 1'b0;
`endif

   always_ff @(posedge interfaceClk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;

   always_comb begin
      after_dummy = (info.rd || info.wr) && len != '0 ? DATA : GAP;
      after_addr = info.has_dummy && DUMMY_CYCLES != 0 ? DUMMY : after_dummy;
      nxt = state;
      case (state)
         IDLE:  if (cmdValid) nxt = CMD;
         CMD:   if (byte_end) nxt = info.has_addr ? ADDR : after_dummy;
         ADDR:  if (byte_end && acnt == 3'd0) nxt = after_addr;
         DUMMY: if (byte_end && dcnt == 16'd0) nxt = after_dummy;
         DATA:  if (byte_end && len == '0) nxt = GAP;
`ifdef SPI_FLASH_WIP_POLL_EN
         POLL:  if (byte_end && poll_rd && !rx[0]) nxt = GAP;
         GAP:   if (gap_end) nxt = poll_go ? POLL : IDLE;
`else
         GAP:   if (gap_end) nxt = IDLE;
`endif
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      cmdReady = state == IDLE;
      busy = !cmdReady;
      en = state != IDLE && state != GAP;
      ld_valid = state == DATA && info.wr ? WrDataValid : 1'b1;
      ld_bits = state == DUMMY ? (dcnt > 16'd8 ? 4'd8 : dcnt[3:0]) : 4'd8;
      ld_byte = state == CMD ? op :
                state == ADDR ? addr_sh[8*ADDR_BYTES-1 -: 8] :
                state == DATA && info.wr ? fData_WR : 8'h00;
`ifdef SPI_FLASH_WIP_POLL_EN
      if (state == POLL && !poll_rd) ld_byte = OP_RDSR;
`endif
      WrDataReady = need && state == DATA && info.wr;
      done = gap_end && !poll_go;
   end

   always_ff @(posedge interfaceClk or posedge reset)
      if (reset) begin
         op <= '0;
         info <= '0;
         addr_sh <= '0;
         len <= '0;
         acnt <= '0;
         dcnt <= '0;
         gcnt <= '0;
         CS_n <= 1'b1;
         fData_RD <= '0;
         RdDataValid <= 1'b0;
`ifdef SPI_FLASH_WIP_POLL_EN
         polled <= 1'b0;
         poll_rd <= 1'b0;
`endif
      end else begin
         RdDataValid <= byte_end && state == DATA && info.rd;
         if (byte_end && state == DATA && info.rd) fData_RD <= rx;
         if (cmdValid && cmdReady) begin
            op <= fCommand;
            info <= decode(fCommand);
            addr_sh <= fAddress;
            len <= fLength;
            acnt <= 3'(ADDR_BYTES);
            dcnt <= 16'(DUMMY_CYCLES);
            CS_n <= 1'b0;
`ifdef SPI_FLASH_WIP_POLL_EN
            polled <= 1'b0;
`endif
         end
         if (load && state == ADDR) begin
            addr_sh <= addr_sh << 8;
            acnt <= acnt - 3'd1;
         end
         if (load && state == DUMMY) dcnt <= dcnt - 16'(ld_bits);
         if (load && state == DATA) len <= len - LEN_W'(1);
         gcnt <= state == GAP ? gcnt + 16'd1 : 16'd0;
         // CS_n rises one half-bit after the final rising MCLK edge
         if (state == GAP && gcnt == DIV_TOP) CS_n <= 1'b1;
`ifdef SPI_FLASH_WIP_POLL_EN
         if (gap_end && poll_go) begin
            CS_n <= 1'b0;
            polled <= 1'b1;
         end
         poll_rd <= state == POLL && (poll_rd || byte_end);
`endif
      end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed checks of spi_flash_ctrl against a bit-level mode-3 flash model.
module tb_spi_flash_ctrl;
   logic interfaceClk = 1'b0, reset = 1'b1, cmdValid = 1'b0, WrDataValid = 1'b0, MISO;
   logic [7:0] fCommand = '0, fData_WR = '0, fData_RD;
   logic [23:0] fAddress = '0;
   logic [8:0] fLength = '0;
   logic cmdReady, WrDataReady, RdDataValid, busy, done, MOSI, MCLK, CS_n;
   int n_cmp = 0, n_bad = 0;

   spi_flash_ctrl #(.CLK_DIV(2), .ADDR_BYTES(3), .DUMMY_CYCLES(8), .LEN_W(9)) dut (
      .interfaceClk(interfaceClk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .fCommand(fCommand), .fAddress(fAddress), .fLength(fLength), .fData_WR(fData_WR),
      .WrDataValid(WrDataValid), .WrDataReady(WrDataReady), .fData_RD(fData_RD),
      .RdDataValid(RdDataValid), .busy(busy), .done(done), .MISO(MISO), .MOSI(MOSI),
      .MCLK(MCLK), .CS_n(CS_n)
   );

   always #5 interfaceClk = ~interfaceClk;

   // flash model: one record per CS_n-low segment; MISO driven from resp after pre falling edges
   int fcnt = 0, rcnt = 0, pre = 0;
   logic [127:0] sr = '0;
   logic [63:0] resp = '0;
   int seg_q[$];
   logic [127:0] sr_q[$];
   always @(posedge CS_n or MCLK)
      if (CS_n) begin
         if (rcnt != 0 || fcnt != 0) begin
            seg_q.push_back(rcnt);
            sr_q.push_back(sr);
         end
         rcnt = 0;
         fcnt = 0;
         sr = '0;
         MISO = 1'b0;
      end else if (MCLK) begin
         sr = {sr[126:0], MOSI};
         rcnt++;
      end else begin
         fcnt++;
         MISO = fcnt > pre && fcnt - pre <= 64 ? resp[64 - (fcnt - pre)] : 1'b0;
      end

   logic [7:0] rd_q[$];
   int wr_rdy_n = 0, done_n = 0;
   always @(negedge interfaceClk) begin
      if (RdDataValid) rd_q.push_back(fData_RD);
      if (WrDataReady) wr_rdy_n++;
      if (done) done_n++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear();
      seg_q.delete();
      sr_q.delete();
      rd_q.delete();
      wr_rdy_n = 0;
      done_n = 0;
   endtask

   task automatic start_cmd(input logic [7:0] op, input logic [23:0] a, input logic [8:0] l);
      int t;
      t = 0;
      while (!cmdReady && t < 1000) begin
         @(negedge interfaceClk);
         t++;
      end
      chk("cmd_ready", cmdReady, 1);
      fCommand = op;
      fAddress = a;
      fLength = l;
      cmdValid = 1'b1;
      @(negedge interfaceClk);
      cmdValid = 1'b0;
   endtask

   task automatic wait_done(output int hi, output int blow);
      int t;
      t = 0;
      hi = 0;
      blow = 0;
      while (!done && t < 20000) begin
         @(negedge interfaceClk);
         t++;
         hi = CS_n ? hi + 1 : 0;
         blow += int'(!busy);
      end
      chk("done_seen", done, 1);
      @(negedge interfaceClk);
   endtask

   task automatic wr_bytes(input logic [23:0] d, input int n, input int stall_at, output int mlow);
      int t;
      mlow = 0;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!WrDataReady && t < 1000) begin
            @(negedge interfaceClk);
            t++;
         end
         chk("wr_ready", WrDataReady, 1);
         if (i == stall_at)
            repeat (20) begin
               @(negedge interfaceClk);
               mlow += int'(!MCLK);
            end
         fData_WR = d[23 - 8*i -: 8];
         WrDataValid = 1'b1;
         @(negedge interfaceClk);
         WrDataValid = 1'b0;
      end
   endtask

   function automatic logic [63:0] rd_at(input int i);
      return rd_q.size() > i ? 64'(rd_q[i]) : 64'hdead;
   endfunction

   function automatic logic [63:0] seg_at(input int i);
      return seg_q.size() > i ? 64'(seg_q[i]) : 64'hdead;
   endfunction

   function automatic logic [127:0] sr_at(input int i);
      return sr_q.size() > i ? sr_q[i] : '1;
   endfunction

   initial begin
      int k, hi, blow, mlow, t;
      repeat (3) @(negedge interfaceClk);
      chk("rst_cs_n", CS_n, 1);
      chk("rst_mclk", MCLK, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmdReady, 1);
      chk("rst_wr_ready", WrDataReady, 0);
      chk("rst_rd_valid", RdDataValid, 0);
      chk("rst_rd_data", fData_RD, 0);
      clear();
      reset = 1'b0;

      // 03 read, accepted on the first cycle out of reset
      pre = 32;
      resp = {8'hA5, 8'h3C, 48'h0};
      start_cmd(8'h03, 24'h012345, 9'd2);
      chk("read_cs_fall", CS_n, 0);
      k = 0;
      while (MCLK && k < 20) begin
         @(negedge interfaceClk);
         k++;
      end
      chk("read_first_fall", k, 2);
      wait_done(hi, blow);
      chk("read_bits", seg_at(0), 48);
      chk("read_mosi", sr_at(0)[47:16], 32'h03012345);
      chk("read_count", rd_q.size(), 2);
      chk("read_byte0", rd_at(0), 8'hA5);
      chk("read_byte1", rd_at(1), 8'h3C);
      chk("read_done_n", done_n, 1);
      chk("read_busy_low", blow, 0);

      // 0B fast read: 8 dummy clocks between address and data
      clear();
      pre = 40;
      resp = {8'hC3, 56'h0};
      start_cmd(8'h0B, 24'h000100, 9'd1);
      wait_done(hi, blow);
      chk("fread_bits", seg_at(0), 48);
      chk("fread_mosi", sr_at(0)[47:16], 32'h0B000100);
      chk("fread_count", rd_q.size(), 1);
      chk("fread_byte0", rd_at(0), 8'hC3);

      // 02 page program, 20-cycle stall before the second byte
      clear();
      pre = 8;
      resp = '0;
      start_cmd(8'h02, 24'hABCDEF, 9'd3);
      wr_bytes(24'h112233, 3, 1, mlow);
      chk("pp_stall_mclk", mlow, 0);
      wait_done(hi, blow);
      chk("pp_bits", seg_at(0), 56);
      chk("pp_hdr", sr_at(0)[55:24], 32'h02ABCDEF);
      chk("pp_data", sr_at(0)[23:0], 24'h112233);
      chk("pp_rd_count", rd_q.size(), 0);
      chk("pp_done_n", done_n, 1);

      // 06 with a nonzero length: opcode only
      clear();
      start_cmd(8'h06, 24'h000000, 9'd5);
      wait_done(hi, blow);
      chk("wren_bits", seg_at(0), 8);
      chk("wren_mosi", sr_at(0)[7:0], 8'h06);
      chk("wren_wr_ready", wr_rdy_n, 0);
      chk("wren_cs_high", hi >= 4, 1);
      chk("wren_ready_after", cmdReady, 1);
      chk("wren_done_n", done_n, 1);

      // reset in the middle of the address phase
      start_cmd(8'h03, 24'h123456, 9'd4);
      t = 0;
      while (rcnt < 12 && t < 2000) begin
         @(negedge interfaceClk);
         t++;
      end
      chk("mid_addr_reached", rcnt >= 12, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_cs_n", CS_n, 1);
      chk("mid_rst_mclk", MCLK, 1);
      chk("mid_rst_busy", busy, 0);
      @(negedge interfaceClk);
      reset = 1'b0;
      clear();
      pre = 8;
      resp = {8'hEF, 8'h40, 8'h18, 40'h0};
      start_cmd(8'h9F, 24'h000000, 9'd3);
      wait_done(hi, blow);
      chk("rdid_bits", seg_at(0), 32);
      chk("rdid_byte0", rd_at(0), 8'hEF);
      chk("rdid_byte1", rd_at(1), 8'h40);
      chk("rdid_byte2", rd_at(2), 8'h18);
      chk("rdid_done_n", done_n, 1);

`ifdef SPI_FLASH_WIP_POLL_EN
      // 02 followed by status polling: 01, 01, 00
      clear();
      pre = 8;
      resp = {8'h01, 8'h01, 8'h00, 40'h0};
      start_cmd(8'h02, 24'h000010, 9'd1);
      wr_bytes(24'h5A0000, 1, -1, mlow);
      wait_done(hi, blow);
      chk("poll_segments", seg_q.size(), 2);
      chk("poll_pp_bits", seg_at(0), 40);
      chk("poll_bits", seg_at(1), 32);
      chk("poll_opcode", sr_at(1)[31:24], 8'h05);
      chk("poll_busy_low", blow, 0);
      chk("poll_rd_count", rd_q.size(), 0);
      chk("poll_done_n", done_n, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
